// File: rtl/program_loader.sv
// Byte-stream boot loader: takes a 16-bit word count, a little-endian program image and an
// XOR checksum, writes the image into instruction memory and releases the core on success.
module program_loader #(
    parameter int data_bits           = 32,
    parameter int memory_size         = 1024,
    parameter int memory_address_bits = $clog2(memory_size)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic                           rx_ready,
    output logic                           mem_write,
    output logic [memory_address_bits-1:0] mem_address,
    output logic [data_bits-1:0]           mem_data_in,
    output logic                           core_hold,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE, ERROR} state_t;

    localparam logic [16:0] MaxWords = 17'(memory_size);

    state_t                         state_q;
    logic [15:0]                    wordCount_q;
    logic [memory_address_bits-1:0] wordIdx_q;
    logic [1:0]                     byteIdx_q;
    logic [7:0]                     checksum_q;
    logic [23:0]                    wordLow_q;

    logic                 accept;
    logic [15:0]          headerCount;
    logic                 headerBad;
    logic [data_bits-1:0] wordFull;
    logic                 lastWord;

    assign accept      = rx_valid && rx_ready;
    assign headerCount = {rx_data, wordCount_q[7:0]};
    assign headerBad   = (headerCount == 16'd0) || ({1'b0, headerCount} > MaxWords);
    // The fourth byte is taken straight off the bus so the word is complete in the WRITE cycle.
    assign wordFull    = data_bits'({rx_data, wordLow_q});
    assign lastWord    = (16'(wordIdx_q) == wordCount_q - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wordCount_q <= '0;
            wordIdx_q   <= '0;
            byteIdx_q   <= '0;
            checksum_q  <= '0;
            wordLow_q   <= '0;
            rx_ready    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            core_hold   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q    <= HDR0;
                        rx_ready   <= 1'b1;
                        busy       <= 1'b1;
                        core_hold  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        wordIdx_q  <= '0;
                        byteIdx_q  <= '0;
                        checksum_q <= '0;
                    end
                end
                HDR0: begin
                    if (accept) begin
                        wordCount_q[7:0] <= rx_data;
                        state_q          <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        wordCount_q <= headerCount;
                        if (headerBad) begin
                            state_q  <= ERROR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        case (byteIdx_q)
                            2'd0:    wordLow_q[7:0]   <= rx_data;
                            2'd1:    wordLow_q[15:8]  <= rx_data;
                            2'd2:    wordLow_q[23:16] <= rx_data;
                            default: ;
                        endcase
                        checksum_q <= checksum_q ^ rx_data;
                        byteIdx_q  <= byteIdx_q + 2'd1;
                        if (byteIdx_q == 2'd3) begin
                            state_q     <= WRITE;
                            rx_ready    <= 1'b0;
                            mem_write   <= 1'b1;
                            mem_address <= wordIdx_q;
                            mem_data_in <= wordFull;
                        end
                    end
                end
                WRITE: begin
                    rx_ready <= 1'b1;
                    if (lastWord) begin
                        state_q <= CHK;
                    end else begin
                        wordIdx_q <= wordIdx_q + 1'b1;
                        state_q   <= DATA;
                    end
                end
                CHK: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (rx_data == checksum_q) begin
                            state_q   <= DONE;
                            core_hold <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_q <= ERROR;
                            error   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and randomized image loads with rx_valid gaps, checked
// against an image-level model of the expected memory writes and load outcome.
module tb_program_loader;

    localparam int MemSize  = 1024;
    localparam int AddrBits = 10;

    logic                clk      = 1'b0;
    logic                reset    = 1'b0;
    logic                start    = 1'b0;
    logic [7:0]          rx_data  = 8'd0;
    logic                rx_valid = 1'b0;
    logic                rx_ready;
    logic                mem_write;
    logic [AddrBits-1:0] mem_address;
    logic [31:0]         mem_data_in;
    logic                core_hold;
    logic                busy;
    logic                done;
    logic                error;

    program_loader #(
        .data_bits(32),
        .memory_size(MemSize),
        .memory_address_bits(AddrBits)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .core_hold(core_hold),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] image [MemSize];
    logic [41:0] expWrites [$];
    logic [41:0] expHead;
    logic        prevWrite  = 1'b0;
    logic [31:0] lastData   = 32'd0;
    int          writeCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] imageChecksum(input int n);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
                x ^= image[i][8*b +: 8];
        return x;
    endfunction

    // Presents one byte until it is taken; gap mode also toggles start to prove it is ignored.
    task automatic sendByte(input logic [7:0] b, input bit gaps);
        bit sent = 1'b0;
        for (int t = 0; t < 1000 && !sent; t++) begin
            @(negedge clk);
            start = gaps ? 1'($urandom_range(1, 0)) : 1'b0;
            if (gaps && $urandom_range(1, 0) == 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                sent     = rx_ready;
            end
        end
        if (!sent) checkOutput("rxTimeout", 0, 1);
    endtask

    task automatic applyStimulus(input int n, input bit badChk, input bit gaps);
        logic [7:0] chk;
        bit legal = (n >= 1) && (n <= MemSize);
        bit ok    = legal && !badChk;
        @(negedge clk);
        start    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAfterStart", busy, 1);
        checkOutput("holdAfterStart", core_hold, 1);
        checkOutput("doneAfterStart", done, 0);
        checkOutput("errorAfterStart", error, 0);
        checkOutput("readyInHeader", rx_ready, 1);
        if (legal)
            for (int i = 0; i < n; i++) expWrites.push_back({10'(i), image[i]});
        sendByte(8'(n), gaps);
        sendByte(8'(n >> 8), gaps);
        if (legal) begin
            for (int i = 0; i < n; i++)
                for (int b = 0; b < 4; b++)
                    sendByte(image[i][8*b +: 8], gaps);
            chk = imageChecksum(n);
            if (badChk) chk = ~chk;
            sendByte(chk, gaps);
        end
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("doneFlag", done, ok);
        checkOutput("errorFlag", error, !ok);
        checkOutput("coreHold", core_hold, !ok);
        checkOutput("busyAfterLoad", busy, 0);
        checkOutput("readyAfterLoad", rx_ready, 0);
        checkOutput("pendingWrites", expWrites.size(), 0);
        expWrites.delete();
    endtask

    always @(negedge clk) begin
        if (mem_write) begin
            checkOutput("rxReadyInWrite", rx_ready, 0);
            checkOutput("singleCycleWrite", prevWrite, 0);
            if (expWrites.size() == 0) begin
                checkOutput("unexpectedWrite", 1, 0);
            end else begin
                expHead = expWrites.pop_front();
                checkOutput("writeAddr", mem_address, expHead[41:32]);
                checkOutput("writeData", mem_data_in, expHead[31:0]);
            end
            lastData = mem_data_in;
            writeCount++;
        end
        checkOutput("holdVsDone", core_hold, !done);
        checkOutput("busyExclusive", busy && (done || error), 0);
        prevWrite = mem_write;
    end

    task automatic checkResetState();
        checkOutput("rstReady", rx_ready, 0);
        checkOutput("rstWrite", mem_write, 0);
        checkOutput("rstAddr", mem_address, 0);
        checkOutput("rstData", mem_data_in, 0);
        checkOutput("rstHold", core_hold, 1);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstError", error, 0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState();
        reset = 1'b1;
        @(negedge clk);

        image[0] = 32'h00000513;
        checkOutput("modelChk1", imageChecksum(1), 8'h16);
        writeCount = 0;
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("t1Writes", writeCount, 1);
        checkOutput("t1Data", lastData, 32'h00000513);

        image[0] = 32'h00100093;
        image[1] = 32'h00200113;
        image[2] = 32'h002081B3;
        checkOutput("modelChk3", imageChecksum(3), 8'hA3);
        writeCount = 0;
        applyStimulus(3, 1'b0, 1'b0);
        checkOutput("t2Writes", writeCount, 3);
        checkOutput("t2LastData", lastData, 32'h002081B3);

        applyStimulus(3, 1'b1, 1'b0);
        applyStimulus(3, 1'b0, 1'b0);

        writeCount = 0;
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1025, 1'b0, 1'b0);
        checkOutput("hdrErrWrites", writeCount, 0);

        for (int i = 0; i < 4; i++) image[i] = $urandom;
        applyStimulus(4, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) image[i] = $urandom;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expWrites.push_back({10'd0, image[0]});
        sendByte(8'd3, 1'b0);
        sendByte(8'd0, 1'b0);
        for (int b = 0; b < 4; b++) sendByte(image[0][8*b +: 8], 1'b0);
        sendByte(image[1][7:0], 1'b0);
        sendByte(image[1][15:8], 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        checkResetState();
        checkOutput("abortWrites", expWrites.size(), 0);
        expWrites.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        image[0] = $urandom;
        applyStimulus(1, 1'b0, 1'b0);

        repeat (12) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) image[i] = $urandom;
            applyStimulus(n, $urandom_range(0, 3) == 0, 1'b1);
        end

        for (int i = 0; i < MemSize; i++) image[i] = $urandom;
        writeCount = 0;
        applyStimulus(MemSize, 1'b0, 1'b0);
        checkOutput("fullWrites", writeCount, MemSize);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader that writes a program image into instruction memory through that memory's write port, while holding the segmented core in reset.
- Receives a 2-byte word count, 4·N data bytes and a 1-byte XOR checksum over a valid/ready byte interface.
- Assembles little-endian 32-bit words and writes each one to consecutive word addresses.
- Releases the core only after the image loads with a correct checksum.

Parameters:
- data_bits, 32, instruction word width (byte assembly requires 32).
- memory_size, 1024, instruction memory depth in words.
- memory_address_bits, $clog2(memory_size), word-address width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data holds a valid byte.
- rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready at the clk edge.
- mem_write  output  1  instruction-memory write strobe, one cycle per word.
- mem_address  output  memory_address_bits  word address of the current write.
- mem_data_in  output  data_bits  word being written.
- core_hold  output  1  holds the core (PC and pipeline registers) in reset while 1.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- error  output  1  last load failed (bad length or checksum).

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - rx_ready=0, mem_write=0, mem_address=0, mem_data_in=0.
  - core_hold=1, busy=0, done=0, error=0.
  - Internal word count, word counter, byte index and checksum all clear to 0.
  - Reset mid-load aborts at once; words already written stay in memory.
- States: IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE, ERROR.
- IDLE:
  - core_hold=1, rx_ready=0.
  - On start: go to HDR0; clear done, error, word counter, byte index, checksum.
- HDR0 (rx_ready=1): on transfer, N[7:0]=rx_data; go to HDR1.
- HDR1 (rx_ready=1): on transfer, N[15:8]=rx_data. Then:
  - If N==0 or N>memory_size: go to ERROR.
  - Otherwise: go to DATA.
- DATA (rx_ready=1): on transfer:
  - Byte b is placed at word[8·idx+7 : 8·idx], little-endian.
  - checksum ^= b; idx increments modulo 4.
  - On the 4th byte (idx==3): go to WRITE.
  - The assembled word drives mem_data_in from the cycle after the 4th byte is accepted.
- WRITE (rx_ready=0, exactly one cycle):
  - mem_write=1, mem_address=word counter, mem_data_in=assembled word.
  - Next cycle: if counter==N-1 go to CHK, else increment the counter and return to DATA.
  - mem_write is 0 in every other state.
- Throughput: peak rate is 4 bytes per 5 cycles. rx_valid may drop at any time; the loader waits without timeout.
- CHK (rx_ready=1): on transfer:
  - If rx_data==checksum: go to DONE.
  - Otherwise: go to ERROR.
- DONE: core_hold=0, done=1, busy=0. The core runs; start re-enters HDR0 and sets core_hold=1.
- ERROR: core_hold=1, error=1, busy=0. start re-enters HDR0.
- busy=1 in HDR0, HDR1, DATA, WRITE and CHK.
- core_hold is a registered output. It falls one cycle after the checksum byte is accepted and rises in the same cycle the state leaves DONE.
- start is ignored in every busy state.
- Bytes presented while rx_ready=0 are not consumed; the sender must hold them.
- mem_address is held between writes; width is exactly memory_address_bits.
- N==memory_size is legal; the final write goes to address memory_size-1.

Test Plan:
- Reset, then pulse start; send 01 00, then 13 05 00 00, then checksum 16 -> exactly one write: mem_address=0, mem_data_in=0x00000513. Then done=1, core_hold=0, error=0.
- N=3 with words 0x00100093, 0x00200113, 0x002081B3, correct XOR checksum -> three single-cycle writes at addresses 0, 1, 2 with those values. rx_ready is 0 during each WRITE cycle; done=1 at the end.
- Same image, checksum byte inverted -> error=1, done=0, core_hold stays 1. A following start plus a correct image gives done=1.
- Header 00 00, and separately header 01 04 (N=1025) -> ERROR directly after HDR1, no mem_write pulses, error=1.
- Random rx_valid gaps (about 50% duty) during an N=4 load -> same write sequence and data as the gap-free load; no byte lost or duplicated.
- Assert reset during DATA of the 2nd word -> all outputs return to reset values immediately with core_hold=1. start plus a fresh N=1 load then completes with done=1.
